// File: rtl/vnu_accum.sv
// vnu_accum -- serial variable-node accumulator for the LDPC decoder.
//
// Takes one channel LLR and DEGREE check-to-variable messages per variable
// node, forms the a-posteriori sum (APP) and then streams DEGREE extrinsic
// messages (APP minus each stored message) over a valid/ready handshake.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   llr_in/llr_valid      channel LLR input; llr_ready high in IDLE only
//   msg_in/msg_valid      check-to-variable messages; msg_ready high in COLLECT
//   ext_out/ext_valid     extrinsic message output; ext_ready from downstream
//   app_out               APP sum of the last completed frame
//   busy                  high whenever a frame is in progress
//
// Optional feature: define VNU_SAT_EXT_EN to clip ext_out to the message
// range [-2^MSG_W, 2^MSG_W-1] (sign-extended to ACC_W+1 bits). app_out is
// never clipped.
module vnu_accum #(
  parameter int MSG_W  = 8,
  parameter int ACC_W  = 10,
  parameter int DEGREE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [MSG_W:0] llr_in,
  input  logic                llr_valid,
  output logic                llr_ready,
  input  logic signed [MSG_W:0] msg_in,
  input  logic                msg_valid,
  output logic                msg_ready,
  output logic signed [ACC_W:0] ext_out,
  output logic                ext_valid,
  input  logic                ext_ready,
  output logic signed [ACC_W:0] app_out,
  output logic                busy
);

  localparam int CW = (DEGREE > 1) ? $clog2(DEGREE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEGREE - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  state_t                 state_q;
  logic signed [ACC_W:0]  acc_q;
  logic signed [ACC_W:0]  app_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          idx_q;
  logic signed [MSG_W:0]  buf_q [DEGREE];

  logic signed [ACC_W:0]  acc_d;
  logic signed [ACC_W:0]  diff;

  function automatic logic signed [ACC_W:0] sext(input logic signed [MSG_W:0] v);
    return {{(ACC_W - MSG_W){v[MSG_W]}}, v};
  endfunction

`ifdef VNU_SAT_EXT_EN
  // Clip to the narrow message range so downstream only ever sees values
  // representable in MSG_W+1 bits.
  function automatic logic signed [ACC_W:0] sat_msg(input logic signed [ACC_W:0] v);
    logic signed [ACC_W:0] maxv;
    logic signed [ACC_W:0] minv;
    maxv = '0;
    maxv[MSG_W-1:0] = '1;
    minv = '1;
    minv[MSG_W-1:0] = '0;
    if (v > maxv)      return maxv;
    else if (v < minv) return minv;
    else               return v;
  endfunction
`endif

  // Output side is purely a function of registered state; no input reaches
  // ext_out/app_out combinationally.
  always_comb begin
    acc_d = acc_q + sext(msg_in);
    diff  = acc_q - sext(buf_q[idx_q]);
    ext_out = '0;
    if (state_q == EMIT) begin
`ifdef VNU_SAT_EXT_EN
      ext_out = sat_msg(diff);
`else
      ext_out = diff;
`endif
    end
  end

  // llr_ready is masked by rst so no LLR is taken in a reset cycle.
  assign llr_ready = (state_q == IDLE) && !rst;
  assign msg_ready = (state_q == COLLECT);
  assign ext_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign app_out   = app_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      app_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < DEGREE; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (llr_valid) begin
            acc_q   <= sext(llr_in);
            cnt_q   <= '0;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (msg_valid) begin
            buf_q[cnt_q] <= msg_in;
            acc_q        <= acc_d;
            cnt_q        <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              // app_q is only updated here so it stays stable through EMIT
              // and holds the last frame's sum afterwards.
              app_q   <= acc_d;
              idx_q   <= '0;
              state_q <= EMIT;
            end
          end
        end
        EMIT: begin
          if (ext_ready) begin
            if (idx_q == LAST) begin
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vnu_accum.sv
module tb_vnu_accum;
  localparam int MSG_W = 8;
  localparam int ACC_W = 10;
  localparam int D     = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [MSG_W:0]     llr_in;
  logic               llr_valid;
  logic               llr_ready;
  logic [MSG_W:0]     msg_in;
  logic               msg_valid;
  logic               msg_ready;
  logic [ACC_W:0]     ext_out;
  logic               ext_valid;
  logic               ext_ready;
  logic [ACC_W:0]     app_out;
  logic               busy;

  vnu_accum #(.MSG_W(MSG_W), .ACC_W(ACC_W), .DEGREE(D)) dut (
    .clk(clk), .rst(rst),
    .llr_in(llr_in), .llr_valid(llr_valid), .llr_ready(llr_ready),
    .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .ext_out(ext_out), .ext_valid(ext_valid), .ext_ready(ext_ready),
    .app_out(app_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame stimulus settings and observations.
  int fm[D];
  int fgap;
  bit fnoisy;
  int fstall_k;
  int fstall_len;
  int got_ext[D];
  int got_app[D];
  bit timeout, consec, hold_ok, first_vld, post_ready, post_vld;

  // Reference model: plain integer arithmetic on the frame contents.
  function automatic int model_app(input int llr);
    int s = llr;
    for (int k = 0; k < D; k++) s += fm[k];
    return s;
  endfunction

  function automatic int model_ext(input int llr, input int k);
    int v = model_app(llr) - fm[k];
`ifdef VNU_SAT_EXT_EN
    if (v > (1 << MSG_W) - 1) v = (1 << MSG_W) - 1;
    if (v < -(1 << MSG_W))    v = -(1 << MSG_W);
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete frame and records what the DUT presented.
  task automatic do_frame(input int llr);
    int n;
    logic [ACC_W:0] v0;
    timeout = 0; consec = 1; hold_ok = 1;
    llr_in = (MSG_W+1)'(llr); llr_valid = 1'b1;
    n = 0;
    while (!llr_ready && n < 100) begin tick(); n++; end
    if (n >= 100) timeout = 1;
    tick();
    llr_valid = 1'b0;
    for (int k = 0; k < D; k++) begin
      msg_valid = 1'b0;
      for (int g = 0; g < fgap; g++) begin
        if (fnoisy) begin llr_valid = 1'b1; llr_in = (MSG_W+1)'(99); end
        tick();
      end
      msg_in = (MSG_W+1)'(fm[k]); msg_valid = 1'b1;
      n = 0;
      while (!msg_ready && n < 100) begin tick(); n++; end
      if (n >= 100) timeout = 1;
      tick();
    end
    msg_valid = 1'b0; llr_valid = 1'b0;
    first_vld = ext_valid;
    for (int k = 0; k < D; k++) begin
      n = 0;
      while (!ext_valid && n < 100) begin consec = 0; tick(); n++; end
      if (n >= 100) timeout = 1;
      if (k == fstall_k) begin
        v0 = ext_out;
        ext_ready = 1'b0;
        for (int s = 0; s < fstall_len; s++) begin
          tick();
          if (ext_valid !== 1'b1 || ext_out !== v0) hold_ok = 0;
        end
      end
      got_ext[k] = $signed(ext_out);
      got_app[k] = $signed(app_out);
      ext_ready = 1'b1;
      tick();
    end
    post_ready = llr_ready;
    post_vld   = ext_valid;
  endtask

  task automatic set_nominal();
    fm[0] = 5; fm[1] = -3; fm[2] = 7;
    fgap = 0; fnoisy = 0; fstall_k = -1; fstall_len = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; llr_valid = 0; msg_valid = 0; ext_ready = 1; llr_in = 0; msg_in = 0;
    tick(); tick();
    checks++;
    if (llr_ready !== 1'b0 || busy !== 1'b0 || ext_valid !== 1'b0 || msg_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl llr_ready=%b busy=%b ext_valid=%b msg_ready=%b need 0000",
               llr_ready, busy, ext_valid, msg_ready);
    end
    checks++;
    if (ext_out !== '0 || app_out !== '0) begin
      errors++;
      $display("FAIL reset_data ext_out=%0d app_out=%0d need 0 0", ext_out, app_out);
    end
    rst = 1'b0; #1;
    checks++;
    if (llr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release llr_ready=%b need 1", llr_ready);
    end
  endtask

  task automatic test_nominal();
    int exp_e[D];
    exp_e[0] = 14; exp_e[1] = 22; exp_e[2] = 12;
    set_nominal();
    do_frame(10);
    for (int k = 0; k < D; k++) begin
      checks++;
      if (got_ext[k] !== exp_e[k] || got_app[k] !== 19) begin
        errors++;
        $display("FAIL nominal_%0d ext=%0d app=%0d need ext=%0d app=19", k, got_ext[k], got_app[k], exp_e[k]);
      end
    end
    checks++;
    if (timeout || !first_vld || !consec || post_ready !== 1'b1 || post_vld !== 1'b0) begin
      errors++;
      $display("FAIL nominal_timing to=%b first_vld=%b consec=%b post_ready=%b post_vld=%b need 0 1 1 1 0",
               timeout, first_vld, consec, post_ready, post_vld);
    end
  endtask

  task automatic test_extremes();
    set_nominal();
    fm[0] = 255; fm[1] = 255; fm[2] = 255;
    do_frame(255);
    for (int k = 0; k < D; k++) begin
      checks++;
      if (got_ext[k] !== model_ext(255, k) || got_app[k] !== 1020) begin
        errors++;
        $display("FAIL pos_extreme_%0d ext=%0d app=%0d need ext=%0d app=1020", k, got_ext[k], got_app[k], model_ext(255, k));
      end
    end
    fm[0] = -256; fm[1] = -256; fm[2] = -256;
    do_frame(-256);
    for (int k = 0; k < D; k++) begin
      checks++;
      if (got_ext[k] !== model_ext(-256, k) || got_app[k] !== -1024) begin
        errors++;
        $display("FAIL neg_extreme_%0d ext=%0d app=%0d need ext=%0d app=-1024", k, got_ext[k], got_app[k], model_ext(-256, k));
      end
    end
    checks++;
    if ($signed(app_out) !== -1024) begin
      errors++;
      $display("FAIL app_retain app_out=%0d need -1024", $signed(app_out));
    end
  endtask

  task automatic test_backpressure();
    set_nominal();
    fstall_k = 1; fstall_len = 5;
    do_frame(10);
    checks++;
    if (!hold_ok || got_ext[1] !== 22 || got_ext[2] !== 12 || timeout || !consec) begin
      errors++;
      $display("FAIL backpressure hold=%b ext1=%0d ext2=%0d to=%b consec=%b need 1 22 12 0 1",
               hold_ok, got_ext[1], got_ext[2], timeout, consec);
    end
  endtask

  task automatic test_stall_ignore();
    msg_valid = 1'b1; msg_in = (MSG_W+1)'(50);
    tick(); tick();
    msg_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || msg_ready !== 1'b0 || llr_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_msg_ignored busy=%b msg_ready=%b llr_ready=%b need 0 0 1", busy, msg_ready, llr_ready);
    end
    set_nominal();
    fgap = 2; fnoisy = 1;
    do_frame(10);
    checks++;
    if (got_ext[0] !== 14 || got_ext[1] !== 22 || got_ext[2] !== 12 || got_app[0] !== 19) begin
      errors++;
      $display("FAIL stall_frame ext=%0d,%0d,%0d app=%0d need 14,22,12 app=19",
               got_ext[0], got_ext[1], got_ext[2], got_app[0]);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL llr99_not_consumed busy=%b need 0", busy);
    end
  endtask

  task automatic test_reset_midframe();
    llr_in = (MSG_W+1)'(10); llr_valid = 1'b1;
    tick();
    llr_valid = 1'b0;
    msg_valid = 1'b1; msg_in = (MSG_W+1)'(5);  tick();
    msg_in = (MSG_W+1)'(-3); tick();
    msg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || llr_ready !== 1'b1 || ext_valid !== 1'b0 || ext_out !== '0 || app_out !== '0) begin
      errors++;
      $display("FAIL reset_midframe busy=%b llr_ready=%b ext_valid=%b ext=%0d app=%0d need 0 1 0 0 0",
               busy, llr_ready, ext_valid, ext_out, app_out);
    end
    set_nominal();
    do_frame(10);
    checks++;
    if (got_ext[0] !== 14 || got_ext[1] !== 22 || got_ext[2] !== 12) begin
      errors++;
      $display("FAIL after_reset_frame ext=%0d,%0d,%0d need 14,22,12", got_ext[0], got_ext[1], got_ext[2]);
    end
  endtask

  task automatic test_random();
    int llr;
    for (int f = 0; f < 30; f++) begin
      llr = int'($urandom_range(511)) - 256;
      for (int k = 0; k < D; k++) fm[k] = int'($urandom_range(511)) - 256;
      fgap = int'($urandom_range(2));
      fnoisy = 1'($urandom_range(1));
      fstall_k = int'($urandom_range(D)) ;
      fstall_len = int'($urandom_range(3));
      do_frame(llr);
      for (int k = 0; k < D; k++) begin
        checks++;
        if (got_ext[k] !== model_ext(llr, k) || got_app[k] !== model_app(llr)) begin
          errors++;
          $display("FAIL random_f%0d_k%0d ext=%0d app=%0d need ext=%0d app=%0d",
                   f, k, got_ext[k], got_app[k], model_ext(llr, k), model_app(llr));
        end
      end
      checks++;
      if (timeout || !hold_ok || !first_vld || post_ready !== 1'b1) begin
        errors++;
        $display("FAIL random_f%0d_flow to=%b hold=%b first_vld=%b post_ready=%b need 0 1 1 1",
                 f, timeout, hold_ok, first_vld, post_ready);
      end
      if (($urandom_range(3)) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_extremes();
    test_backpressure();
    test_stall_ignore();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
